// File: rtl/ram4_bank.sv
// Four-word register bank with a one-cycle registered read port and a
// multi-cycle clear sequence that zeroes one word per clock.
module ram4_bank #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       address,
  input  logic             load,
  input  logic             rd,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned NUM_WORDS = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       clr_idx;
  logic [WIDTH-1:0] word [NUM_WORDS];
  logic [3:0]       load_en_c;

  // One-hot write enable; a clear request in the same cycle drops the write.
  always_comb begin
    load_en_c = '0;
    if (state == IDLE && load && !clear) begin
      load_en_c = 4'(4'b0001 << address);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_idx   <= '0;
      busy      <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        word[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Read samples the pre-write word, giving read-before-write.
          if (rd) begin
            out       <= word[address];
            out_valid <= 1'b1;
          end
          if (clear) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
          end
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (load_en_c[i]) begin
              word[i] <= in;
            end
          end
        end
        CLEAR: begin
          word[clr_idx] <= '0;
          clr_idx       <= clr_idx + 2'd1;
          if (clr_idx == 2'd3) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram4_bank.sv
// Scoreboard bench for ram4_bank: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_ram4_bank;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] d_in = '0;
  logic [1:0]   address = '0;
  logic         load = 1'b0;
  logic         rd = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: word contents, remaining busy cycles, pending reads.
  logic [W-1:0] model [4];
  int           busy_left = 0;
  logic         vld_want = 1'b0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_out = '0;

  ram4_bank #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in(d_in), .address(address), .load(load),
    .rd(rd), .clear(clear), .out(out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Applies one cycle of inputs and advances the model across the coming edge.
  task automatic drive(input logic l, input logic r, input logic c,
                       input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    check("busy", 32'(busy), 32'(busy_left > 0));
    check("out_valid", 32'(out_valid), 32'(vld_want));
    load = l; rd = r; clear = c; address = a; d_in = d;
    vld_want = r && (busy_left == 0);
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (r) exp_q.push_back(model[a]);
      if (c) begin
        for (int i = 0; i < 4; i++) model[i] = '0;
        busy_left = 4;
      end else if (l) begin
        model[a] = d;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 2'd0, '0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 2'(i), '0);
    idle(1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data.
  initial begin
    logic [W-1:0] want;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_out = '0;
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'(0));
        end else begin
          want = exp_q.pop_front();
          check("read_data", 32'(out), 32'(want));
        end
        last_out = out;
      end else begin
        check("out_hold", 32'(out), 32'(last_out));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) model[i] = '0;
    #1;
    check("reset_out", 32'(out), 32'(0));
    check("reset_valid", 32'(out_valid), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    #11 rst_n = 1'b1;

    // Decode isolation: only word3 written.
    drive(1'b1, 1'b0, 1'b0, 2'd3, 16'hFFFF);
    read_all();

    // Write all words, then back-to-back reads.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 2'(i), W'(16'h1111 * (i + 1)));
    read_all();

    // Clear with a load during busy that must be ignored.
    drive(1'b0, 1'b0, 1'b1, 2'd0, '0);
    drive(1'b1, 1'b0, 1'b0, 2'd2, 16'hBEEF);
    drive(1'b0, 1'b1, 1'b1, 2'd1, '0);
    idle(3);
    read_all();

    // load+clear conflict, then read-before-write on address 1.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 16'h1234);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 16'hCAFE);
    idle(4);
    drive(1'b0, 1'b1, 1'b0, 2'd0, '0);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 16'h00AA);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 16'h5555);
    drive(1'b0, 1'b1, 1'b0, 2'd1, '0);
    idle(1);

    // Async reset in the second clear cycle, after a read+clear.
    drive(1'b0, 1'b1, 1'b1, 2'd1, '0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, '0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'(0));
    check("async_out", 32'(out), 32'(0));
    check("async_valid", 32'(out_valid), 32'(0));
    for (int i = 0; i < 4; i++) model[i] = '0;
    busy_left = 0;
    vld_want = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    read_all();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 5),
            1'($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)), W'($urandom));
    end
    idle(6);
    read_all();

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
